// File: rtl/edulent_mem_responder_if.sv
// Bundle between the edulent core/program loader and the memory responder.
// The master side is the core plus loader; the slave side is the responder.
interface edulent_mem_responder_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  // Core data-memory bus
  logic [ADDR_W-1:0] i_mem_addr;
  logic              i_mem_write_enable;
  logic [DATA_W-1:0] i_mem_data_write;
  logic [DATA_W-1:0] o_mem_data_read;

  // Program loader byte stream
  logic              i_load_start;
  logic              i_load_valid;
  logic [DATA_W-1:0] i_load_data;
  logic              i_load_last;
  logic              o_load_ready;

  // Core control and status
  logic              o_core_rstn;
  logic              o_busy;
  logic              o_wr_fault;
  logic [ADDR_W:0]   o_load_count;

  modport master (
    output i_mem_addr, i_mem_write_enable, i_mem_data_write,
    output i_load_start, i_load_valid, i_load_data, i_load_last,
    input  o_mem_data_read, o_load_ready, o_core_rstn, o_busy,
    input  o_wr_fault, o_load_count
  );

  modport slave (
    input  i_mem_addr, i_mem_write_enable, i_mem_data_write,
    input  i_load_start, i_load_valid, i_load_data, i_load_last,
    output o_mem_data_read, o_load_ready, o_core_rstn, o_busy,
    output o_wr_fault, o_load_count
  );
endinterface

// File: rtl/edulent_mem_responder.sv
// Unified program/data RAM for the edulent core with a byte-stream program
// loader. The loader holds the core in reset, copies the program from
// address 0, zero-fills the remainder, then releases the core. While the
// core runs, addresses below RO_LIMIT reject core writes and pulse a fault.
module edulent_mem_responder #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RO_LIMIT = {ADDR_W{1'b0}}
) (
  input logic                    i_clk,
  input logic                    i_rst,
  edulent_mem_responder_if.slave bus
);

  localparam int unsigned       DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DAT_ZERO = {DATA_W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CLEAR   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4
  } state_e;

  state_e            state_r;
  logic [ADDR_W-1:0] load_ptr_r;
  logic [ADDR_W-1:0] clr_ptr_r;
  logic [ADDR_W:0]   load_count_r;
  logic              load_ready_r;
  logic              core_rstn_r;
  logic              busy_r;
  logic              wr_fault_r;

  logic [DATA_W-1:0] mem_r [0:DEPTH-1];

  logic              ro_hit_s;
  logic              load_accept_s;
  logic              core_blocked_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  // With RO_LIMIT of zero there is no protected region, so avoid a
  // compare that would be constant.
  generate
    if (RO_LIMIT == PTR_ZERO) begin : g_no_protect
      assign ro_hit_s = 1'b0;
    end else begin : g_protect
      assign ro_hit_s = (bus.i_mem_addr < RO_LIMIT);
    end
  endgenerate

  assign load_accept_s  = (state_r == ST_LOAD) && bus.i_load_valid && load_ready_r;
  assign core_blocked_s = (state_r == ST_RUN) && bus.i_mem_write_enable && ro_hit_s;

  // Select the single RAM write port source: loader byte, clear, or core write.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = bus.i_mem_addr;
    mem_wdata_s = bus.i_mem_data_write;
    case (state_r)
      ST_LOAD: begin
        if (load_accept_s) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = load_ptr_r;
          mem_wdata_s = bus.i_load_data;
        end else begin
          mem_we_s    = 1'b0;
        end
      end
      ST_CLEAR: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = clr_ptr_r;
        mem_wdata_s = DAT_ZERO;
      end
      ST_RUN: begin
        if (bus.i_mem_write_enable && !ro_hit_s) begin
          mem_we_s = 1'b1;
        end else begin
          mem_we_s = 1'b0;
        end
      end
      default: begin
        mem_we_s = 1'b0;
      end
    endcase
  end

  // RAM array; contents deliberately survive reset, so only writes are gated.
  always_ff @(posedge i_clk) begin
    if (mem_we_s && !i_rst) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Sequencer: loader handshake, clear sweep, core release and status flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r      <= ST_IDLE;
      load_ptr_r   <= PTR_ZERO;
      clr_ptr_r    <= PTR_ZERO;
      load_count_r <= CNT_ZERO;
      load_ready_r <= 1'b0;
      core_rstn_r  <= 1'b0;
      busy_r       <= 1'b0;
      wr_fault_r   <= 1'b0;
    end else begin
      wr_fault_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.i_load_start) begin
            state_r      <= ST_LOAD;
            load_ptr_r   <= PTR_ZERO;
            load_count_r <= CNT_ZERO;
            load_ready_r <= 1'b1;
            busy_r       <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (load_accept_s) begin
            load_ptr_r   <= load_ptr_r + PTR_ONE;
            load_count_r <= load_count_r + CNT_ONE;
            if (load_ptr_r == PTR_MAX) begin
              // RAM is full: nothing left to clear.
              state_r      <= ST_RELEASE;
              load_ready_r <= 1'b0;
            end else if (bus.i_load_last) begin
              state_r      <= ST_CLEAR;
              clr_ptr_r    <= load_ptr_r + PTR_ONE;
              load_ready_r <= 1'b0;
            end
          end
        end
        ST_CLEAR: begin
          clr_ptr_r <= clr_ptr_r + PTR_ONE;
          if (clr_ptr_r == PTR_MAX) begin
            state_r <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          state_r     <= ST_RUN;
          core_rstn_r <= 1'b1;
          busy_r      <= 1'b0;
        end
        ST_RUN: begin
          if (core_blocked_s) begin
            wr_fault_r <= 1'b1;
          end
          if (bus.i_load_start) begin
            // A coincident core write is still committed by the RAM port.
            state_r      <= ST_LOAD;
            load_ptr_r   <= PTR_ZERO;
            load_count_r <= CNT_ZERO;
            load_ready_r <= 1'b1;
            busy_r       <= 1'b1;
            core_rstn_r  <= 1'b0;
          end
        end
        default: begin
          // Unreachable encoding: park safely with the core held in reset.
          state_r      <= ST_IDLE;
          load_ready_r <= 1'b0;
          core_rstn_r  <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_mem_data_read = (state_r == ST_RUN) ? mem_r[bus.i_mem_addr] : DAT_ZERO;
  assign bus.o_load_ready    = load_ready_r;
  assign bus.o_core_rstn     = core_rstn_r;
  assign bus.o_busy          = busy_r;
  assign bus.o_wr_fault      = wr_fault_r;
  assign bus.o_load_count    = load_count_r;

endmodule
